nt_level_integrator: RTL

// - Consumer side of the neurotransmitter regulator interface: takes inc/dec/fast from one

---
 rtl/nt_level_integrator.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/nt_level_integrator.sv
// Integrates inc/dec/fast requests from one neurotransmitter regulator into a saturating
// concentration accumulator and publishes its quantised 2-bit level. Optional decay: NT_DECAY_EN.
module nt_level_integrator #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      TICK_DIV  = 4,
    parameter int unsigned      STEP_SLOW = 1,
    parameter int unsigned      STEP_FAST = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(8'h80),
    parameter int unsigned      DECAY_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             inc,
    input  logic             dec,
    input  logic             fast,
    output logic [1:0]       level,
    output logic [WIDTH-1:0] conc,
    output logic             changed,
    output logic [1:0]       trend
);

    localparam int unsigned      PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [WIDTH:0]   STEP_SLOW_X = (WIDTH + 1)'(STEP_SLOW);
    localparam logic [WIDTH:0]   STEP_FAST_X = (WIDTH + 1)'(STEP_FAST);
    localparam logic [WIDTH-1:0] CONC_MAX    = '1;

    typedef enum logic [1:0] {
        TR_STEADY  = 2'b00,
        TR_RISING  = 2'b01,
        TR_FALLING = 2'b10
    } trend_e;

    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] conc_q, conc_d;
    logic             changed_q, changed_d;
    trend_e           trend_q, trend_d;

    logic             tick;
    logic             req_inc;
    logic             req_dec;
    logic [WIDTH:0]   step;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             decay_fire;
    logic [WIDTH-1:0] decay_val;

    // Prescaler: the phase only advances on enabled cycles.
    always_comb begin
        tick    = ena && (presc_q == PRESC_LAST);
        presc_d = presc_q;
        if (ena) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    assign req_inc = tick && inc && !dec;
    assign req_dec = tick && dec && !inc;

`ifdef NT_DECAY_EN
    localparam int unsigned      DW         = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DW-1:0]    DECAY_LAST = DW'(DECAY_DIV - 1);
    localparam logic [WIDTH-1:0] MID        = {1'b1, {(WIDTH - 1){1'b0}}};

    logic [DW-1:0] decay_cnt_q, decay_cnt_d;
    logic          req_none;

    // Idle ticks (no request, or conflicting requests) pull conc one step toward MID.
    always_comb begin
        req_none    = tick && (inc == dec);
        decay_fire  = req_none && (decay_cnt_q == DECAY_LAST);
        decay_cnt_d = decay_cnt_q;
        if (req_inc || req_dec) begin
            decay_cnt_d = '0;
        end else if (req_none) begin
            decay_cnt_d = decay_fire ? '0 : decay_cnt_q + 1'b1;
        end
        decay_val = conc_q;
        if (conc_q > MID) begin
            decay_val = conc_q - 1'b1;
        end else if (conc_q < MID) begin
            decay_val = conc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            decay_cnt_q <= '0;
        end else begin
            decay_cnt_q <= decay_cnt_d;
        end
    end
`else
    logic unused_decay_div;

    assign decay_fire       = 1'b0;
    assign decay_val        = conc_q;
    assign unused_decay_div = DECAY_DIV[0];
`endif

    // One extra bit of headroom catches overflow/underflow before saturation.
    always_comb begin
        step   = fast ? STEP_FAST_X : STEP_SLOW_X;
        sum    = {1'b0, conc_q} + step;
        diff   = {1'b0, conc_q} - step;
        conc_d = conc_q;
        if (req_inc) begin
            conc_d = sum[WIDTH] ? CONC_MAX : sum[WIDTH-1:0];
        end else if (req_dec) begin
            conc_d = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
        end else if (decay_fire) begin
            conc_d = decay_val;
        end
        changed_d = (conc_d[WIDTH-1:WIDTH-2] != conc_q[WIDTH-1:WIDTH-2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            conc_q    <= RESET_VAL;
            changed_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            conc_q    <= conc_d;
            changed_q <= changed_d;
        end
    end

    // Trend FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            trend_q <= TR_STEADY;
        end else begin
            trend_q <= trend_d;
        end
    end

    // Trend FSM: next state, evaluated on ticks only; saturation does not matter here.
    always_comb begin
        trend_d = trend_q;
        if (tick) begin
            if (inc && !dec) begin
                trend_d = TR_RISING;
            end else if (dec && !inc) begin
                trend_d = TR_FALLING;
            end else begin
                trend_d = TR_STEADY;
            end
        end
    end

    // Trend FSM: output decode.
    always_comb begin
        case (trend_q)
            TR_RISING:  trend = 2'b01;
            TR_FALLING: trend = 2'b10;
            default:    trend = 2'b00;
        endcase
    end

    assign level   = conc_q[WIDTH-1:WIDTH-2];
    assign conc    = conc_q;
    assign changed = changed_q;

endmodule
